nes_cpu_bus_dma: RTL
====================

# nes_cpu_bus_dma

CPU-side bus controller for the NES top level: a parametrised successor to the single-mask PPU chip-select decode. Fully decodes the 6502 address space into one-hot target selects with mirroring and muxes synchronous read data back to the CPU. Adds an OAM DMA engine: a CPU write to the DMA page register halts the CPU and copies `DMA_LEN` bytes from `page:00` onward to the PPU OAM data port.

## Interface
Parameters:
- `RAM_AW`, 11, internal RAM address width; RAM is mirrored across $0000-$1FFF
- `PPU_RW`, 3, PPU register index width; registers are mirrored across $2000-$3FFF
- `DMA_LEN`, 256, bytes per DMA transfer, range 1..256
- `DMA_REG`, 16'h4014, DMA page register address
- `OAM_DATA`, 16'h2004, DMA write destination address

Ports:
- `clk` in 1: system clock, the only clock
- `reset` in 1: synchronous, active-high
- `cpu_addr` in 16; `cpu_dout` in 8; `cpu_we` in 1; `cpu_rd` in 1: CPU bus request
- `cpu_din` out 8: read data to the CPU
- `cpu_rdy` out 1: low halts the CPU
- `bus_addr` out 16; `bus_wdata` out 8; `bus_we` out 1; `bus_rd` out 1: shared target bus
- `ram_addr` out `RAM_AW`; `ppu_reg` out `PPU_RW`: mirrored local addresses
- `ram_cs`, `io_cs`, `exp_cs`, `sram_cs`, `prg_cs` out 1: active-high selects
- `ppu_n_cs` out 1: active-low PPU select
- `ram_rdata`, `ppu_rdata`, `io_rdata`, `cart_rdata` in 8: target read data, valid one cycle after the `bus_rd` cycle

## Operation
- Address map, decoded from `bus_addr`:
  - $0000-$1FFF → ram
  - $2000-$3FFF → ppu
  - $4000-$401F → io
  - $4020-$5FFF → exp
  - $6000-$7FFF → sram
  - $8000-$FFFF → prg
- Exactly one select is active while `bus_rd|bus_we`; all are inactive otherwise, with `ppu_n_cs`=1.
- `ram_addr` = `bus_addr[RAM_AW-1:0]`; `ppu_reg` = `bus_addr[PPU_RW-1:0]`.
- Read-data mux select for a cycle: exp, sram and prg use `cart_rdata`.
- Outside DMA, the bus is a combinational pass-through of the CPU request.
- Read return:
  - The target class is registered on each `bus_rd` cycle.
  - In the next cycle, `cpu_din` = the selected rdata, and that value is captured into a hold register.
  - In all other cycles, `cpu_din` = the hold register (open-bus behaviour).
- Parity bit: cleared by reset, toggles every cycle.
- FSM states: IDLE, HALT, ALIGN, READ, WRITE.
  - IDLE: `cpu_rdy`=1. A `cpu_we` to `DMA_REG` latches `page`=`cpu_dout` and clears `idx`; the write is also forwarded to io; next state HALT.
  - HALT: `cpu_rdy`=0, bus idle.
    - With `DMA_ODD_ALIGN_EN` and parity=1: next state ALIGN.
    - Otherwise: next state READ.
  - ALIGN: bus idle, next state READ.
  - READ: `bus_addr`={`page`,`idx`}, `bus_rd`=1, next state WRITE.
  - WRITE: `bus_addr`=`OAM_DATA`, `bus_we`=1, `bus_wdata`= the rdata mux output for the READ target. `idx`++.
    - If `idx`==`DMA_LEN-1`: next state IDLE.
    - Otherwise: next state READ.
- While `cpu_rdy`=0, CPU requests are ignored and never reach the bus; this includes a second `DMA_REG` write.
- `idx` is 8 bits; a DMA from page $FF reads $FF00-$FFFF with no wrap into $0000.
- DMA reads may target any region, including $2000-$3FFF.

## Timing
- Reset values: state IDLE; `cpu_rdy`=1; `cpu_din`=0; `bus_we`=`bus_rd`=0; all selects inactive; `bus_addr`=0; `bus_wdata`=0; parity=0.
- A `DMA_REG` write in cycle T drops `cpu_rdy` in cycle T+1.
- `cpu_rdy` stays low for 1 + align + 2·`DMA_LEN` cycles and returns high the cycle after the last WRITE. For `DMA_LEN`=256 this is 513 cycles, or 514 when aligned.
- READ→WRITE latency is 1 cycle; there is one OAM write every 2 cycles.
- Reset asserted mid-DMA: the next cycle is IDLE with `cpu_rdy`=1, and no further `bus_we` is issued.

## Configuration
- `DMA_ODD_ALIGN_EN` defined: HALT on odd parity inserts one ALIGN cycle (513/514-cycle behaviour of the real console).
- `DMA_ODD_ALIGN_EN` undefined: no ALIGN state; HALT always goes to READ, giving a fixed 1+2·`DMA_LEN` cycles.

## Test plan
- Decode: reads at $0000, $1ABC, $3FFF, $4016, $5000, $6000, $8000 → single selects ram, ram (`ram_addr`=$2BC), ppu (`ppu_reg`=7, `ppu_n_cs`=0), io, exp, sram, prg.
- Read return: `ppu_rdata`=$A5 in the cycle after a $2002 read → `cpu_din`=$A5, still $A5 three idle cycles later.
- DMA from page $02 with RAM preloaded with `i^$5A`, started at parity 0 → 256 writes to $2004 with data $5A,$5B,…; `cpu_rdy` low for exactly 513 cycles.
- Same DMA at parity 1, macro on → 514 cycles low and the first READ one cycle later; macro off → 513.
- `reset` pulsed after 40 OAM writes → `cpu_rdy`=1 next cycle, no `bus_we` afterwards; a following DMA runs a full 256 writes.
- CPU write to $0300 presented during DMA → no RAM write and no bus change; DMA count remains 256.

Source files
------------

// File: rtl/nes_cpu_bus_dma.sv
// nes_cpu_bus_dma: CPU-side bus controller with OAM DMA.
//
// Decodes the 6502 address space into one-hot target selects with mirroring,
// returns synchronous read data to the CPU with open-bus hold, and runs an OAM
// DMA engine. A CPU write to DMA_REG halts the CPU and copies DMA_LEN bytes
// from page:00 onward to OAM_DATA.
//
// Optional feature: define DMA_ODD_ALIGN_EN to insert one ALIGN cycle when the
// HALT cycle falls on odd parity (513/514-cycle console behaviour).
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   cpu_addr/cpu_dout/cpu_we/cpu_rd   CPU request
//   cpu_din, cpu_rdy                  read data to CPU, CPU halt (low)
//   bus_addr/bus_wdata/bus_we/bus_rd  shared target bus
//   ram_addr, ppu_reg                 mirrored local addresses
//   ram_cs/io_cs/exp_cs/sram_cs/prg_cs active-high selects
//   ppu_n_cs                          active-low PPU select
//   ram/ppu/io/cart_rdata             target read data, one cycle after bus_rd
module nes_cpu_bus_dma #(
  parameter int unsigned RAM_AW   = 11,
  parameter int unsigned PPU_RW   = 3,
  parameter int unsigned DMA_LEN  = 256,
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_DATA = 16'h2004
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_we,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_din,
  output logic              cpu_rdy,
  output logic [15:0]       bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_we,
  output logic              bus_rd,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [PPU_RW-1:0] ppu_reg,
  output logic              ram_cs,
  output logic              io_cs,
  output logic              exp_cs,
  output logic              sram_cs,
  output logic              prg_cs,
  output logic              ppu_n_cs,
  input  logic [7:0]        ram_rdata,
  input  logic [7:0]        ppu_rdata,
  input  logic [7:0]        io_rdata,
  input  logic [7:0]        cart_rdata
);

`ifdef DMA_ODD_ALIGN_EN
  typedef enum logic [2:0] {StIdle, StHalt, StAlign, StRead, StWrite} state_e;
`else
  typedef enum logic [2:0] {StIdle, StHalt, StRead, StWrite} state_e;
`endif

  typedef enum logic [1:0] {TgtRam, TgtPpu, TgtIo, TgtCart} tgt_e;

  localparam logic [7:0] LastIdx = 8'(DMA_LEN - 1);

  state_e     state_q;
  logic [7:0] page_q;
  logic [7:0] idx_q;
  logic       cpu_rdy_q;
  logic       parity_q;

  logic       rd_valid_q;
  tgt_e       rd_tgt_q;
  logic [7:0] hold_q;

  logic [7:0] rdata_mux;
  tgt_e       bus_tgt;
  logic       bus_act;
  logic       sel_ram, sel_ppu, sel_io, sel_exp, sel_sram, sel_prg;

  // Read data for the target registered on the previous bus_rd cycle.
  always_comb begin
    rdata_mux = cart_rdata;
    case (rd_tgt_q)
      TgtRam:  rdata_mux = ram_rdata;
      TgtPpu:  rdata_mux = ppu_rdata;
      TgtIo:   rdata_mux = io_rdata;
      default: rdata_mux = cart_rdata;
    endcase
  end

  // Bus source: CPU pass-through in IDLE, DMA engine otherwise. Gated by reset
  // so a reset landing on a WRITE cycle cannot issue one more OAM write.
  always_comb begin
    bus_addr  = 16'h0000;
    bus_wdata = 8'h00;
    bus_we    = 1'b0;
    bus_rd    = 1'b0;
    if (!reset) begin
      case (state_q)
        StIdle: begin
          bus_addr  = cpu_addr;
          bus_wdata = cpu_dout;
          bus_we    = cpu_we;
          bus_rd    = cpu_rd;
        end
        StRead: begin
          bus_addr = {page_q, idx_q};
          bus_rd   = 1'b1;
        end
        StWrite: begin
          bus_addr  = OAM_DATA;
          bus_wdata = rdata_mux;
          bus_we    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Address decode.
  always_comb begin
    sel_ram  = (bus_addr[15:13] == 3'b000);
    sel_ppu  = (bus_addr[15:13] == 3'b001);
    sel_io   = (bus_addr[15:5] == 11'h200);
    sel_exp  = (bus_addr[15:13] == 3'b010) && !sel_io;
    sel_sram = (bus_addr[15:13] == 3'b011);
    sel_prg  = bus_addr[15];
    if (sel_ram) begin
      bus_tgt = TgtRam;
    end else if (sel_ppu) begin
      bus_tgt = TgtPpu;
    end else if (sel_io) begin
      bus_tgt = TgtIo;
    end else begin
      bus_tgt = TgtCart;
    end
  end

  assign bus_act  = bus_rd | bus_we;
  assign ram_cs   = bus_act & sel_ram;
  assign io_cs    = bus_act & sel_io;
  assign exp_cs   = bus_act & sel_exp;
  assign sram_cs  = bus_act & sel_sram;
  assign prg_cs   = bus_act & sel_prg;
  assign ppu_n_cs = ~(bus_act & sel_ppu);
  assign ram_addr = bus_addr[RAM_AW-1:0];
  assign ppu_reg  = bus_addr[PPU_RW-1:0];

  // Fresh data in the cycle after a read; otherwise the last value (open bus).
  assign cpu_din = rd_valid_q ? rdata_mux : hold_q;
  assign cpu_rdy = cpu_rdy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_tgt_q   <= TgtRam;
      hold_q     <= 8'h00;
    end else begin
      rd_valid_q <= bus_rd;
      if (bus_rd) begin
        rd_tgt_q <= bus_tgt;
      end
      if (rd_valid_q) begin
        hold_q <= rdata_mux;
      end
    end
  end

  // DMA FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      page_q    <= 8'h00;
      idx_q     <= 8'h00;
      cpu_rdy_q <= 1'b1;
      parity_q  <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
      case (state_q)
        StIdle: begin
          if (cpu_we && (cpu_addr == DMA_REG)) begin
            page_q    <= cpu_dout;
            idx_q     <= 8'h00;
            cpu_rdy_q <= 1'b0;
            state_q   <= StHalt;
          end
        end
        StHalt: begin
`ifdef DMA_ODD_ALIGN_EN
          state_q <= parity_q ? StAlign : StRead;
`else
          state_q <= StRead;
`endif
        end
`ifdef DMA_ODD_ALIGN_EN
        StAlign: state_q <= StRead;
`endif
        StRead: state_q <= StWrite;
        StWrite: begin
          idx_q <= idx_q + 8'd1;
          if (idx_q == LastIdx) begin
            cpu_rdy_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            state_q <= StRead;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
